median_window_fifo: RTL and testbench

MEDIAN_WINDOW_FIFO -- requirements
Module: median_window_fifo

---
 rtl/median_window_fifo_pkg.sv | 22 ++
 rtl/median_window_fifo_window_ram.sv | 25 ++
 rtl/median_window_fifo.sv | 136 +++++++++++++
 tb/tb_median_window_fifo.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/median_window_fifo_pkg.sv
// Shared types and default sizing for the median window FIFO.
// Holds the FSM state encoding and the window-size clamp helper.
package median_window_fifo_pkg;

  localparam int DEF_DATA_LENGTH = 8;
  localparam int DEF_WMAX        = 8;
  localparam int DEF_LOG_WMAX    = 3;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A zero request still needs one slot; oversize requests saturate at the buffer depth.
  function automatic int unsigned clamp_win(input int unsigned w_req, input int unsigned wmax);
    if (w_req == 0) return 1;
    if (w_req > wmax) return wmax;
    return w_req;
  endfunction

endpackage

// File: rtl/median_window_fifo_window_ram.sv
// Window sample storage: one synchronous write port and an asynchronous read port.
// Both ports share one address, so a read in the write cycle returns the old contents.
module window_ram
  import median_window_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int WMAX        = DEF_WMAX,
  parameter int LOG_WMAX    = DEF_LOG_WMAX
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [LOG_WMAX-1:0]    addr_i,
  input  logic [DATA_LENGTH-1:0] wdata_i,
  output logic [DATA_LENGTH-1:0] rdata_o
);

  logic [DATA_LENGTH-1:0] mem_q [WMAX];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/median_window_fifo.sv
// Sliding-window sample FIFO: feeds new samples and their evicted counterparts
// to a median cell array, restarting cleanly whenever the window size changes.
module median_window_fifo
  import median_window_fifo_pkg::*;
#(
  parameter int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int WMAX        = DEF_WMAX,
  parameter int LOG_WMAX    = DEF_LOG_WMAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LOG_WMAX:0]      w,
  input  logic [DATA_LENGTH-1:0] x_in,
  input  logic                   x_valid,
  output logic [DATA_LENGTH-1:0] x_out,
  output logic [DATA_LENGTH-1:0] old_out,
  output logic                   old_valid,
  output logic                   shift,
  output logic                   full,
  output logic [LOG_WMAX:0]      fill_cnt
);

  localparam int WW = LOG_WMAX + 1;

  state_e                 state_q, state_d;
  logic [LOG_WMAX-1:0]    wr_ptr_q, wr_ptr_d, ptr_next;
  logic [WW-1:0]          fill_q, fill_d;
  logic [WW-1:0]          w_act_q, w_act_d;
  logic [WW-1:0]          w_clamp;
  logic                   full_q, full_d;
  logic                   shift_q, shift_d;
  logic                   old_valid_q, old_valid_d;
  logic [DATA_LENGTH-1:0] x_out_q, x_out_d;
  logic [DATA_LENGTH-1:0] old_out_q, old_out_d;
  logic [DATA_LENGTH-1:0] ram_rdata;
  logic                   ram_we;
  logic                   w_change;

  always_comb begin
    w_clamp = WW'(clamp_win(32'(w), WMAX));
  end

  window_ram #(
    .DATA_LENGTH(DATA_LENGTH),
    .WMAX       (WMAX),
    .LOG_WMAX   (LOG_WMAX)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (wr_ptr_q),
    .wdata_i(x_in),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      w_act_q     <= w_clamp;
      full_q      <= 1'b0;
      shift_q     <= 1'b0;
      old_valid_q <= 1'b0;
      x_out_q     <= '0;
      old_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      w_act_q     <= w_act_d;
      full_q      <= full_d;
      shift_q     <= shift_d;
      old_valid_q <= old_valid_d;
      x_out_q     <= x_out_d;
      old_out_q   <= old_out_d;
    end
  end

  // The pointer wraps at the active window, so the entry it addresses is always the oldest sample.
  always_comb begin
    ptr_next = ({1'b0, wr_ptr_q} == (w_act_q - WW'(1))) ? '0 : (wr_ptr_q + LOG_WMAX'(1));
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    w_act_d     = w_act_q;
    full_d      = full_q;
    shift_d     = 1'b0;
    old_valid_d = 1'b0;
    x_out_d     = x_out_q;
    old_out_d   = old_out_q;
    ram_we      = 1'b0;
    w_change    = (state_q != ST_FLUSH) && (w_clamp != w_act_q);

    unique case (state_q)
      ST_FLUSH: begin
        state_d = ST_FILL;
      end
      default: begin
        if (w_change) begin
          state_d  = ST_FLUSH;
          w_act_d  = w_clamp;
          wr_ptr_d = '0;
          fill_d   = '0;
          full_d   = 1'b0;
        end else if (x_valid) begin
          ram_we   = 1'b1;
          wr_ptr_d = ptr_next;
          x_out_d  = x_in;
          shift_d  = 1'b1;
          if (state_q == ST_RUN) begin
            old_out_d   = ram_rdata;
            old_valid_d = 1'b1;
          end else begin
            old_out_d = '0;
            fill_d    = fill_q + WW'(1);
            if ((fill_q + WW'(1)) == w_act_q) begin
              state_d = ST_RUN;
              full_d  = 1'b1;
            end
          end
        end
      end
    endcase
  end

  assign x_out     = x_out_q;
  assign old_out   = old_out_q;
  assign old_valid = old_valid_q;
  assign shift     = shift_q;
  assign full      = full_q;
  assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_median_window_fifo.sv
// Scoreboard bench for median_window_fifo: a queue-based window model predicts
// every output one cycle ahead and the prediction is compared after each edge.
module tb_median_window_fifo;

  localparam int DL   = 8;
  localparam int WMAX = 8;
  localparam int LW   = 3;
  localparam int WW   = LW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [WW-1:0] w;
  logic [DL-1:0] x_in;
  logic          x_valid;
  logic [DL-1:0] x_out;
  logic [DL-1:0] old_out;
  logic          old_valid;
  logic          shift;
  logic          full;
  logic [WW-1:0] fill_cnt;

  always #5 clk = ~clk;

  median_window_fifo #(
    .DATA_LENGTH(DL),
    .WMAX       (WMAX),
    .LOG_WMAX   (LW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .w        (w),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_out    (x_out),
    .old_out  (old_out),
    .old_valid(old_valid),
    .shift    (shift),
    .full     (full),
    .fill_cnt (fill_cnt)
  );

  typedef struct packed {
    logic [DL-1:0] x_out;
    logic [DL-1:0] old_out;
    logic          old_valid;
    logic          shift;
    logic          full;
    logic [WW-1:0] fill;
  } exp_t;

  exp_t          sb_q[$];
  int            checks_cnt = 0;
  int            errors_cnt = 0;

  int            m_wact;
  bit            m_flush;
  logic [DL-1:0] m_win[$];
  logic [DL-1:0] m_xo;
  logic [DL-1:0] m_oo;
  int            cur_w;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_m(input int v);
    if (v == 0) return 1;
    if (v > WMAX) return WMAX;
    return v;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, then compare them.
  task automatic step(input bit rst, input int wv, input bit xv, input int xd);
    exp_t e;
    exp_t got_e;
    int   wc;
    reset   = rst;
    w       = WW'(wv);
    x_valid = xv;
    x_in    = DL'(xd);
    wc      = clamp_m(wv);
    e       = '0;
    if (rst) begin
      m_wact  = wc;
      m_flush = 1'b0;
      m_win.delete();
      m_xo    = '0;
      m_oo    = '0;
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (wc != m_wact) begin
      m_wact  = wc;
      m_flush = 1'b1;
      m_win.delete();
    end else if (xv) begin
      if (m_win.size() == m_wact) begin
        m_oo        = m_win.pop_front();
        e.old_valid = 1'b1;
      end else begin
        m_oo = '0;
      end
      m_win.push_back(DL'(xd));
      m_xo    = DL'(xd);
      e.shift = 1'b1;
    end
    e.x_out   = m_xo;
    e.old_out = m_oo;
    e.fill    = WW'(m_win.size());
    e.full    = (m_win.size() == m_wact);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    check_eq("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      got_e = sb_q.pop_front();
      check_eq("x_out",     32'(x_out),     32'(got_e.x_out));
      check_eq("old_out",   32'(old_out),   32'(got_e.old_out));
      check_eq("old_valid", 32'(old_valid), 32'(got_e.old_valid));
      check_eq("shift",     32'(shift),     32'(got_e.shift));
      check_eq("full",      32'(full),      32'(got_e.full));
      check_eq("fill_cnt",  32'(fill_cnt),  32'(got_e.fill));
    end
  endtask

  initial begin
    reset   = 1'b1;
    w       = '0;
    x_in    = '0;
    x_valid = 1'b0;

    // fill and run with w = 3
    step(1, 3, 0, 0);
    step(1, 3, 1, 77);
    step(0, 3, 1, 5);
    step(0, 3, 1, 7);
    step(0, 3, 1, 9);
    step(0, 3, 1, 11);
    step(0, 3, 1, 13);
    step(0, 3, 0, 0);

    // window change mid-run: changed cycle and flush cycle both drop input
    step(0, 5, 1, 99);
    step(0, 5, 1, 98);
    for (int i = 0; i < 7; i++) step(0, 5, 1, 20 + i);

    // gaps in x_valid with w = 4
    step(0, 4, 1, 200);
    step(0, 4, 0, 0);
    begin
      bit vpat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
      int s = 1;
      for (int i = 0; i < 8; i++) begin
        step(0, 4, vpat[i], vpat[i] ? s : 255);
        if (vpat[i]) s++;
      end
    end
    step(0, 4, 1, 6);

    // oversize request clamps to WMAX; equal clamped value does not flush
    step(0, 15, 1, 0);
    step(0, 15, 0, 0);
    for (int i = 0; i < 2 * WMAX + 1; i++) step(0, (i < 10) ? 15 : WMAX, 1, 100 + i);

    // reset mid-run with a sample presented, w = 0 gives a one-sample window
    step(1, 0, 1, 33);
    step(0, 0, 1, 40);
    step(0, 0, 1, 41);
    step(0, 0, 0, 0);
    step(0, 0, 1, 42);

    // random traffic with occasional window changes and resets
    cur_w = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) cur_w = $urandom_range(0, 15);
      step($urandom_range(0, 99) == 0, cur_w, $urandom_range(0, 3) != 0, $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
